dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Sequencing controller and two-port arbiter in front of the byte-addressed data memory (dmem).
//   Port 0 = core load/store unit, port 1 = DMA/program loader.
//   Accepts one request at a time, validates size/alignment/range, drives one dmem access cycle,
//   then returns a one-cycle response (read data or write ack, plus error flag).
// PARAMETERS
//   ADDR_W     32    byte-address width on requester and memory sides
//   MEM_BYTES  4096  dmem size in bytes; accesses whose last byte is >= MEM_BYTES are errors
// PORTS
//   CLK            in   1       clock, all state on rising edge
//   RST_N          in   1       asynchronous, active-low reset
//   p0_req/p1_req  in   1       request valid; held with fields stable until pN_gnt
//   pN_we          in   1       1 = store, 0 = load
//   pN_addr        in   ADDR_W  byte address
//   pN_wdata       in   32      store data, LSB-aligned
//   pN_ctrl        in   3       000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
//   pN_gnt         out  1       one-cycle pulse: request accepted this cycle
//   pN_rvalid      out  1       one-cycle pulse: response for the accepted request
//   pN_rdata       out  32      load result (already sign/zero-extended by dmem); 0 on store/error
//   pN_err         out  1       valid with pN_rvalid: illegal ctrl, misaligned or out of range
//   mem_addr       out  ADDR_W  to dmem address
//   mem_wdata      out  32      to dmem write data
//   mem_ctrl       out  3       to dmem size/extension code
//   mem_we_n       out  1       active-low write strobe, 1 except on a legal store ACCESS cycle
//   mem_re         out  1       read strobe, 1 only on a legal load ACCESS cycle
//   mem_rdata      in   32      dmem combinational read data
// BEHAVIOUR
//   Reset: FSM=IDLE, all gnt/rvalid/err=0, rdata=0, mem_addr/wdata/ctrl=0, mem_we_n=1, mem_re=0,
//     rr pointer=port 0. Reset mid-access aborts immediately: no write, no rvalid delivered.
//   FSM: IDLE -> ACCESS -> RESP -> IDLE; exactly one request in flight; 3 cycles per access.
//   IDLE: if any req, choose winner (arbitration below), pulse winner gnt (combinational with req),
//     register owner, we, addr, wdata, ctrl, error check result; go ACCESS. No req: stay IDLE.
//   Error check: ctrl not in {000,001,010,100,101}; ctrl 100/101 with we=1; h at addr[0]=1;
//     w at addr[1:0]!=0; addr + bytes - 1 >= MEM_BYTES (computed ADDR_W+1 wide, no wrap).
//   ACCESS: registered fields drive mem_*; legal store -> mem_we_n=0; legal load -> mem_re=1,
//     capture mem_rdata into response register at end of cycle. Errored request: mem_we_n=1,
//     mem_re=0 (no memory side effect). Go RESP.
//   RESP: owner rvalid=1, rdata=captured (0 for store/error), err=registered error; go IDLE.
//     Non-owner rvalid/rdata/err stay 0. Outside RESP, all rdata outputs = 0.
//   Requests arriving in ACCESS/RESP wait; gnt never asserts outside IDLE; no req is dropped.
//   Simultaneous p0_req and p1_req in IDLE: resolved per CONFIGURATION; exactly one gnt.
// CONFIGURATION
//   DMEM_ARB_RR_EN defined: round-robin; rr pointer names the favoured port, and after each
//     grant it moves to the other port; single requester always wins.
//   DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins; pointer logic absent.
// TESTING
//   1 p0 store w addr 0x100 data 0xDEADBEEF, then p0 load w 0x100 -> gnt at T, mem_we_n=0 at T+1,
//     rvalid at T+2 err=0; load returns 0xDEADBEEF at its RESP.
//   2 p1 load b at 0x103 after test 1 (ctrl 000) -> rdata 0xFFFFFFDE; ctrl 100 -> 0x000000DE.
//   3 Misaligned: p0 load w 0x102, store h 0x101, ctrl 011, store with ctrl 100 -> each rvalid
//     with err=1, rdata=0, mem_we_n stays 1 and mem_re stays 0 for the whole access.
//   4 Range: load w at 0xFFC -> err=0; load w at 0xFFD -> err=1; load h at 0xFFF -> err=1.
//   5 p0 and p1 request continuously for 4 grants -> RR_EN: order 0,1,0,1;
//     without macro: 0,0,0,0 and p1 never granted while p0 holds req.
//   6 Assert RST_N=0 during ACCESS of store 0x55 to 0x200 -> outputs at reset values
//     immediately, no rvalid; after release, load b 0x200 returns the pre-test value.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port sequencing controller / arbiter in front of the byte-addressed dmem.
// Latency: grant in the request cycle (IDLE), memory access next cycle, one-cycle response after that.
// Backpressure: one request in flight; other requests stay pending (req held) until granted in IDLE.
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/ctrl  requester N (0 = core LSU, 1 = DMA/loader); fields stable until pN_gnt
//   pN_gnt                     one-cycle accept pulse (combinational with pN_req, IDLE only)
//   pN_rvalid/rdata/err        one-cycle response for the owner; rdata/err are 0 otherwise
//   mem_*                      dmem access port (mem_we_n active-low, mem_re active-high)
// Configuration macro: DMEM_ARB_RR_EN (defined = round-robin, undefined = port 0 fixed priority).
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [2:0]        p0_ctrl,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [2:0]        p1_ctrl,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_ctrl,
  output logic              mem_we_n,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              req_any;
  logic              sel;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_wdata;
  logic [2:0]        s_ctrl;

  // Illegal size code, signed-only store codes, misalignment, or last byte beyond the memory.
  // The end address is formed one bit wider than the address so a top-of-space access cannot wrap.
  function automatic logic chk_err(input logic we, input logic [ADDR_W-1:0] addr,
                                   input logic [2:0] ctrl);
    logic            bad;
    logic [2:0]      nb_m1;
    logic [ADDR_W:0] last;
    bad   = 1'b0;
    nb_m1 = 3'd0;
    case (ctrl)
      3'b000: nb_m1 = 3'd0;
      3'b001: begin nb_m1 = 3'd1; bad = addr[0]; end
      3'b010: begin nb_m1 = 3'd3; bad = |addr[1:0]; end
      3'b100: begin nb_m1 = 3'd0; bad = we; end
      3'b101: begin nb_m1 = 3'd1; bad = we | addr[0]; end
      default: bad = 1'b1;
    endcase
    last = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, nb_m1};
    if (last >= MEM_LIM) bad = 1'b1;
    return bad;
  endfunction

  assign req_any = p0_req | p1_req;

`ifdef DMEM_ARB_RR_EN
  logic rr_q, rr_d;
  // rr_q names the favoured port on a tie; a lone requester always wins.
  assign sel = (p0_req && p1_req) ? rr_q : p1_req;
`else
  assign sel = ~p0_req;
`endif

  assign s_we    = sel ? p1_we    : p0_we;
  assign s_addr  = sel ? p1_addr  : p0_addr;
  assign s_wdata = sel ? p1_wdata : p0_wdata;
  assign s_ctrl  = sel ? p1_ctrl  : p0_ctrl;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
`ifdef DMEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_any) begin
          p0_gnt  = ~sel;
          p1_gnt  = sel;
          owner_d = sel;
          we_d    = s_we;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          ctrl_d  = s_ctrl;
          err_d   = chk_err(s_we, s_addr, s_ctrl);
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          rr_d    = ~rr_q;
`endif
        end
      end
      ACCESS: begin
        // Only a legal load returns data; stores and errored requests respond with zero.
        rdata_d = (!we_q && !err_q) ? mem_rdata : 32'd0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ctrl  = ctrl_q;
  assign mem_we_n  = ~((state_q == ACCESS) && we_q && !err_q);
  assign mem_re    = (state_q == ACCESS) && !we_q && !err_q;

  assign p0_rvalid = (state_q == RESP) && !owner_q;
  assign p1_rvalid = (state_q == RESP) && owner_q;
  assign p0_rdata  = p0_rvalid ? rdata_q : 32'd0;
  assign p1_rdata  = p1_rvalid ? rdata_q : 32'd0;
  assign p0_err    = p0_rvalid & err_q;
  assign p1_err    = p1_rvalid & err_q;

endmodule
